// File: rtl/rr_mux_sequencer_if.sv
// Request/grant bundle between the four requesters and the mux sequencer.
// master: requester side (drives req, observes the mux controls).
// slave : sequencer side (samples req, drives sel/en/grant/busy/done).
interface rr_mux_sequencer_if #(
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req;
  logic [SEL_W-1:0]  sel;
  logic              en;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              done;

  modport master (
    output req,
    input  sel, en, grant, busy, done
  );

  modport slave (
    input  req,
    output sel, en, grant, busy, done
  );
endinterface

// File: rtl/rr_mux_sequencer.sv
// Round-robin sequencer for a 4-channel blanking mux. Grants one channel for
// at most HOLD cycles, then blanks the mux for GAP cycles before sel moves.
// Every output comes straight from a flop; req only reaches the next state.
module rr_mux_sequencer #(
  parameter int HOLD = 4,  // max granted cycles, 1..15
  parameter int GAP  = 1   // blanking cycles after each grant, 0..3
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_mux_sequencer_if.slave   bus
);
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    last, last_nxt;
  logic [SEL_W-1:0]    sel_q, sel_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [1:0]          gcnt, gcnt_nxt;
  logic                en_q, en_nxt;
  logic [NUM_CH-1:0]   grant_q, grant_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;

  logic                pick_vld;
  logic [SEL_W-1:0]    pick;
  logic [SEL_W-1:0]    cand;
  logic                grant_end;

  // Rotating priority search: first requester after the last one served.
  // The offset wraps mod 4, so offset 4 lands back on last itself, which is
  // what lets a sole requester be regranted.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last + SEL_W'(k);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // A grant ends on hold expiry or when its own requester lets go.
  assign grant_end = (cnt == 4'd0) || !bus.req[sel_q];

  // Next-state and datapath: pointer, select, hold and gap counters.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt = S_GRANT;
          last_nxt  = pick;
          sel_nxt   = pick;
          cnt_nxt   = 4'(HOLD - 1);
        end
      end
      S_GRANT: begin
        if (grant_end) begin
          done_nxt = 1'b1;
          if (GAP > 0) begin
            // sel is held through the gap so it only moves while blanked
            state_nxt = S_GAP;
            gcnt_nxt  = 2'(GAP - 1);
          end else if (pick_vld) begin
            state_nxt = S_GRANT;
            last_nxt  = pick;
            sel_nxt   = pick;
            cnt_nxt   = 4'(HOLD - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_GAP: begin
        if (gcnt == 2'd0) begin
          if (pick_vld) begin
            state_nxt = S_GRANT;
            last_nxt  = pick;
            sel_nxt   = pick;
            cnt_nxt   = 4'(HOLD - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gcnt_nxt = gcnt - 2'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered mux controls are a pure function of the upcoming state.
  always_comb begin
    en_nxt    = (state_nxt != S_GRANT);
    busy_nxt  = (state_nxt != S_IDLE);
    grant_nxt = (state_nxt == S_GRANT) ? (4'b0001 << sel_nxt) : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      last    <= 2'd3;
      sel_q   <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      en_q    <= 1'b1;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      sel_q   <= sel_nxt;
      cnt     <= cnt_nxt;
      gcnt    <= gcnt_nxt;
      en_q    <= en_nxt;
      grant_q <= grant_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.en    = en_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // Output invariants seen by the mux.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_q));
  a_grant_vs_en   : assert property (@(posedge clk) disable iff (!rst_n)
    ((grant_q != '0) == !en_q));
  a_grant_vs_sel  : assert property (@(posedge clk) disable iff (!rst_n)
    ((grant_q == '0) || (grant_q == (4'b0001 << sel_q))));
endmodule

// File: tb/tb_rr_mux_sequencer.sv
// Bench for rr_mux_sequencer: three parameter builds driven by the same
// request stream, each compared every cycle against a behavioural model.
module tb_rr_mux_sequencer;
  localparam int N = 3;

  int hold_p [N] = '{4, 2, 1};
  int gap_p  [N] = '{1, 0, 3};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;

  always #5 clk = ~clk;

  rr_mux_sequencer_if b0 ();
  rr_mux_sequencer_if b1 ();
  rr_mux_sequencer_if b2 ();

  assign b0.req = req;
  assign b1.req = req;
  assign b2.req = req;

  rr_mux_sequencer #(.HOLD(4), .GAP(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  rr_mux_sequencer #(.HOLD(2), .GAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  rr_mux_sequencer #(.HOLD(1), .GAP(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // {sel, en, grant, busy, done}
  logic [8:0] obs [N];
  assign obs[0] = {b0.sel, b0.en, b0.grant, b0.busy, b0.done};
  assign obs[1] = {b1.sel, b1.en, b1.grant, b1.busy, b1.done};
  assign obs[2] = {b2.sel, b2.en, b2.grant, b2.busy, b2.done};

  // Model: who owns the mux, how long it has held it, blank cycles left.
  typedef struct {
    int         owner;
    int         held;
    int         gap_left;
    int         ptr;
    logic [1:0] sel;
    bit         done;
  } model_t;

  model_t m [N];

  function automatic model_t step(input model_t s, input logic [3:0] r,
                                  input bit rst, input int hold, input int gap);
    model_t n = s;
    bit try_pick = 1'b0;
    if (!rst) begin
      n.owner = -1; n.held = 0; n.gap_left = 0; n.ptr = 3; n.sel = 2'd0; n.done = 1'b0;
      return n;
    end
    n.done = 1'b0;
    if (s.owner >= 0) begin
      n.held = s.held + 1;
      if (n.held >= hold || !r[s.owner]) begin
        n.done  = 1'b1;
        n.owner = -1;
        if (gap > 0) n.gap_left = gap;
        else         try_pick   = 1'b1;
      end
    end else if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
      try_pick   = (n.gap_left == 0);
    end else begin
      try_pick = 1'b1;
    end
    if (try_pick) begin
      for (int k = 1; k <= 4; k++) begin
        int c = (s.ptr + k) % 4;
        if (n.owner < 0 && r[c]) begin
          n.owner = c; n.ptr = c; n.sel = 2'(c); n.held = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [8:0] expv(input model_t s);
    logic [3:0] g = (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
    return {s.sel, (s.owner < 0), g, (s.owner >= 0 || s.gap_left > 0), s.done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, advance the model at the rising edge,
  // sample the DUTs just after it.
  task automatic tick(input logic [3:0] r, input bit rst);
    @(negedge clk);
    req   = r;
    rst_n = rst;
    @(posedge clk);
    for (int i = 0; i < N; i++) m[i] = step(m[i], r, rst, hold_p[i], gap_p[i]);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("u%0d_cyc%0d", i, cyc), 32'(obs[i]), 32'(expv(m[i])));
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // reset with every requester active
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    chk("rst_outputs", 32'(obs[0]), 32'(9'b00_1_0000_0_0));
    tick(4'b1111, 1'b1);
    chk("rst_release_grant", 32'(b0.grant), 32'(4'b0001));
    repeat (3) tick(4'b1111, 1'b0);

    // sole requester, regranted after each gap
    repeat (14) tick(4'b0001, 1'b1);
    // all requesters rotate
    repeat (26) tick(4'b1111, 1'b1);
    repeat (6) tick(4'b0000, 1'b1);

    // early release of channel 1 after two grant cycles
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    repeat (6) tick(4'b0000, 1'b1);

    // serve channel 3, then wrap to 0
    repeat (3) tick(4'b1000, 1'b1);
    repeat (14) tick(4'b1001, 1'b1);
    repeat (6) tick(4'b0000, 1'b1);

    // reset during the second grant cycle
    tick(4'b0110, 1'b1);
    tick(4'b0110, 1'b1);
    tick(4'b0110, 1'b0);
    tick(4'b1111, 1'b1);
    chk("mid_rst_next_grant", 32'(b0.grant), 32'(4'b0001));

    // two requesters: GAP=0 build switches without blanking
    repeat (12) tick(4'b0011, 1'b1);

    // randomized bursts, occasional reset
    repeat (120) begin
      logic [3:0] r;
      int         len;
      bit         rst;
      r   = 4'($urandom);
      len = $urandom_range(1, 10);
      rst = ($urandom_range(0, 31) != 0);
      tick(r, rst);
      repeat (len) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom);
        tick(r, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
